chacha_block_core: RTL

- Iterative ChaCha block function. Loads a 512-bit state from key, counter and nonce, runs ROUNDS rounds using QR_PAR quarter-round units per cycle, adds the initial state back (feed-forward), and presents one 512-bit keystream block.
- Sits between the key/nonce control logic and the RNG output buffer.
- Generalises the single combinational quarter round: parametrised round count, area/speed trade-off, in/out handshakes, automatic counter advance.

---
 rtl/chacha_block_core.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/chacha_block_core.sv
`timescale 1ns/1ps
// Iterative ChaCha block function: state load, ROUNDS rounds at QR_PAR quarter rounds/cycle, feed-forward add.
// Latency: accept edge 0, out_valid after edge ROUNDS*4/QR_PAR + 1; one block in flight, no overlap.
// Backpressure: block is held stable in HOLD until out_ready; in_ready only while IDLE.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     request handshake; in_next selects stored key/nonce with counter+1
//   key_in/ctr_in/nonce_in  state words 4..11, 12, 13..15 (word i at bits [32i+31:32i])
//   out_valid/out_ready   keystream handshake
//   ks_out                512-bit keystream block (word i at bits [32i+31:32i])
//   ctr_used/ctr_wrap     counter of the presented block, and its all-ones flag
//   busy                  FSM not idle
module chacha_block_core #(
    parameter int ROUNDS = 20,
    parameter int QR_PAR = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_next,
    input  logic [255:0] key_in,
    input  logic [31:0]  ctr_in,
    input  logic [95:0]  nonce_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] ks_out,
    output logic [31:0]  ctr_used,
    output logic         ctr_wrap,
    output logic         busy
);

    generate
        if (ROUNDS < 2 || (ROUNDS % 2) != 0) begin : g_bad_rounds
            $error("chacha_block_core: ROUNDS must be even and >= 2");
        end
        if (QR_PAR != 1 && QR_PAR != 2 && QR_PAR != 4) begin : g_bad_qr_par
            $error("chacha_block_core: QR_PAR must be 1, 2 or 4");
        end
    endgenerate

    localparam int N_STEPS = ROUNDS * 4 / QR_PAR;
    localparam int STEP_W  = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    // Group-steps per half-round; each half-round is four quarter-round groups.
    localparam int GPS     = 4 / QR_PAR;
    localparam logic [1:0]        SUB_LAST  = 2'(GPS - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(N_STEPS - 1);
    // "expand 32-byte k", word 0 in the low 32 bits.
    localparam logic [127:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_FEED,
        S_HOLD
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [255:0]      key_q;
    logic [95:0]       nonce_q;
    logic [31:0]       ctr_q;
    logic [15:0][31:0] work_q;
    logic [15:0][31:0] work_d;
    logic [15:0][31:0] init_q;
    logic [15:0][31:0] ks_q;
    logic [STEP_W-1:0] step_q;
    logic [1:0]        sub_q;   // group-step index inside the current half-round
    logic              diag_q;  // 0 = column half-round, 1 = diagonal half-round

    logic [255:0]      key_sel;
    logic [95:0]       nonce_sel;
    logic [31:0]       ctr_sel;
    logic [15:0][31:0] init_state;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] quarter(input logic [31:0] a_in, input logic [31:0] b_in,
                                             input logic [31:0] c_in, input logic [31:0] d_in);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        a = a_in;
        b = b_in;
        c = c_in;
        d = d_in;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    assign in_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign ks_out   = ks_q;

    // Request selection; the stored registers are all zero after reset, so an
    // in_next request straight after reset naturally yields key 0, nonce 0, counter 1.
    always_comb begin
        key_sel    = in_next ? key_q : key_in;
        nonce_sel  = in_next ? nonce_q : nonce_in;
        ctr_sel    = in_next ? (ctr_q + 32'd1) : ctr_in;
        init_state = {nonce_sel, ctr_sel, key_sel, SIGMA};
    end

    // One group-step: QR_PAR consecutive groups of the current half-round.
    // Group g of a half-round touches words (g, 4+(g+k), 8+(g+2k), 12+(g+3k)) mod 4 per row,
    // with k = 0 for columns and k = 1 for diagonals; the 2-bit adds wrap the row offset.
    always_comb begin
        work_d = work_q;
        for (int u = 0; u < QR_PAR; u++) begin
            logic [1:0]  g;
            logic [3:0]  ia;
            logic [3:0]  ib;
            logic [3:0]  ic;
            logic [3:0]  id;
            logic [31:0] qa;
            logic [31:0] qb;
            logic [31:0] qc;
            logic [31:0] qd;
            g  = 2'(int'(sub_q) * QR_PAR + u);
            ia = {2'b00, g};
            ib = {2'b01, 2'(g + {1'b0, diag_q})};
            ic = {2'b10, 2'(g + {diag_q, 1'b0})};
            id = {2'b11, 2'(g + {diag_q, diag_q})};
            {qa, qb, qc, qd} = quarter(work_q[ia], work_q[ib], work_q[ic], work_q[id]);
            work_d[ia] = qa;
            work_d[ib] = qb;
            work_d[ic] = qc;
            work_d[id] = qd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_ROUND;
            S_ROUND: if (step_q == STEP_LAST) state_d = S_FEED;
            S_FEED:  state_d = S_HOLD;
            S_HOLD:  if (out_valid && out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q     <= '0;
            nonce_q   <= '0;
            ctr_q     <= '0;
            work_q    <= '0;
            init_q    <= '0;
            ks_q      <= '0;
            step_q    <= '0;
            sub_q     <= '0;
            diag_q    <= 1'b0;
            ctr_used  <= '0;
            ctr_wrap  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        key_q   <= key_sel;
                        nonce_q <= nonce_sel;
                        ctr_q   <= ctr_sel;
                        work_q  <= init_state;
                        init_q  <= init_state;
                        step_q  <= '0;
                        sub_q   <= '0;
                        diag_q  <= 1'b0;
                    end
                end
                S_ROUND: begin
                    work_q <= work_d;
                    step_q <= step_q + STEP_W'(1);
                    if (sub_q == SUB_LAST) begin
                        sub_q  <= '0;
                        diag_q <= ~diag_q;
                    end else begin
                        sub_q <= sub_q + 2'd1;
                    end
                end
                S_FEED: begin
                    for (int i = 0; i < 16; i++) begin
                        ks_q[i] <= work_q[i] + init_q[i];
                    end
                    ctr_used  <= ctr_q;
                    ctr_wrap  <= &ctr_q;
                    out_valid <= 1'b1;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        ctr_wrap  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
